// File: rtl/ans_pkg.sv
// ans_pkg: shared definitions for the ANS pin-level input blocks.
// - Default table geometry: SYM_COUNT, CNT_WIDTH, PROB_BITS.
// - sum_w(): width of the running sum and of each CDF entry.
// - loader_state_e: the table loader state machine.
package ans_pkg;

    localparam int DEF_SYM_COUNT = 16;
    localparam int DEF_CNT_WIDTH = 8;
    localparam int DEF_PROB_BITS = 8;

    // Summing SYM_COUNT words of CNT_WIDTH bits needs $clog2(SYM_COUNT)
    // extra bits, so the accumulator can never overflow.
    function automatic int sum_w(input int sym_count, input int cnt_width);
        return cnt_width + $clog2(sym_count);
    endfunction

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_DONE = 2'd1,
        ST_ERR  = 2'd2
    } loader_state_e;

endpackage

// File: rtl/ans_hs_rx.sv
// ans_hs_rx: 4-phase handshake receiver.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset (in_rdy returns to 1)
//   clear   - synchronous restart, same effect as rst
//   enable  - receiver may accept words; when low in_rdy is driven to 0
//   in_vld  - request from the sender
//   in_rdy  - registered acknowledge; high means ready for a word
//   accept  - one-cycle strobe: the word on the bus is taken at this edge
module ans_hs_rx (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic in_vld,
    output logic in_rdy,
    output logic accept
);

    logic in_rdy_reg;
    logic in_rdy_next;

    always_comb begin
        // A clear in the same cycle discards the word, so no accept then.
        accept      = in_rdy_reg && in_vld && enable && !clear && !rst;
        in_rdy_next = in_rdy_reg;
        if (!enable) begin
            in_rdy_next = 1'b0;
        end else if (accept) begin
            in_rdy_next = 1'b0;
        end else if (!in_rdy_reg && !in_vld) begin
            // Sender has released its request: re-arm for the next word.
            in_rdy_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            in_rdy_reg <= 1'b1;
        end else begin
            in_rdy_reg <= in_rdy_next;
        end
    end

    assign in_rdy = in_rdy_reg;

endmodule

// File: rtl/ans_table_loader.sv
// ans_table_loader: receives SYM_COUNT symbol counts over a 4-phase
// handshake, stores the frequency table, builds the CDF on the fly and
// flags whether the counts total 2^PROB_BITS.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clear      - synchronous reload request (same effect as rst)
//   in         - count word for the next symbol
//   in_vld     - 4-phase request; in_rdy - 4-phase acknowledge
//   counts     - flattened count table, symbol i at [i*CNT_WIDTH +: CNT_WIDTH]
//   cdf        - flattened CDF, entry i at [i*SUM_W +: SUM_W], cdf[0] = 0
//   load_idx   - index of the next symbol to be written
//   tbl_vld    - table complete and total correct
//   err        - table complete and total wrong
module ans_table_loader
    import ans_pkg::*;
#(
    parameter  int SYM_COUNT = DEF_SYM_COUNT,
    parameter  int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter  int PROB_BITS = DEF_PROB_BITS,
    localparam int SYM_W     = $clog2(SYM_COUNT),
    localparam int SUM_W     = sum_w(SYM_COUNT, CNT_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic [CNT_WIDTH-1:0]           in,
    input  logic                           in_vld,
    output logic                           in_rdy,
    output logic [SYM_COUNT*CNT_WIDTH-1:0] counts,
    output logic [SYM_COUNT*SUM_W-1:0]     cdf,
    output logic [SYM_W-1:0]               load_idx,
    output logic                           tbl_vld,
    output logic                           err
);

    localparam logic [31:0] TOTAL = 32'd1 << PROB_BITS;

    loader_state_e    state_reg, state_next;
    logic [SUM_W-1:0] acc_reg;
    logic [SUM_W-1:0] acc_next;
    logic [SYM_W-1:0] load_idx_reg;
    logic             tbl_vld_reg, tbl_vld_next;
    logic             err_reg, err_next;
    logic             accept;
    logic             last_word;

    ans_hs_rx u_hs_rx (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .enable (state_reg == ST_LOAD),
        .in_vld (in_vld),
        .in_rdy (in_rdy),
        .accept (accept)
    );

    assign acc_next  = acc_reg + SUM_W'(in);
    assign last_word = (load_idx_reg == SYM_W'(SYM_COUNT - 1));

    // Next state plus the registered status flags; the total is checked on
    // the last accept itself so the verdict appears one cycle later.
    always_comb begin
        state_next   = state_reg;
        tbl_vld_next = tbl_vld_reg;
        err_next     = err_reg;
        case (state_reg)
            ST_LOAD: begin
                if (accept && last_word) begin
                    if (32'(acc_next) == TOTAL) begin
                        state_next   = ST_DONE;
                        tbl_vld_next = 1'b1;
                    end else begin
                        state_next = ST_ERR;
                        err_next   = 1'b1;
                    end
                end
            end
            default: begin
                // DONE and ERR hold until rst or clear.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_reg    <= ST_LOAD;
            acc_reg      <= '0;
            load_idx_reg <= '0;
            tbl_vld_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tbl_vld_reg <= tbl_vld_next;
            err_reg     <= err_next;
            if (accept) begin
                acc_reg      <= acc_next;
                load_idx_reg <= last_word ? '0 : load_idx_reg + 1'b1;
            end
        end
    end

    // One count/CDF register pair per symbol; each entry loads only when
    // its own index is being accepted.
    genvar gi;
    generate
        for (gi = 0; gi < SYM_COUNT; gi++) begin : g_entry
            logic [CNT_WIDTH-1:0] count_reg;
            logic [SUM_W-1:0]     cdf_reg;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    count_reg <= '0;
                    cdf_reg   <= '0;
                end else if (accept && (load_idx_reg == SYM_W'(gi))) begin
                    count_reg <= in;
                    cdf_reg   <= acc_reg;
                end
            end

            assign counts[gi*CNT_WIDTH +: CNT_WIDTH] = count_reg;
            assign cdf[gi*SUM_W +: SUM_W]            = cdf_reg;
        end
    endgenerate

    assign load_idx = load_idx_reg;
    assign tbl_vld  = tbl_vld_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_ans_table_loader.sv
// Testbench for ans_table_loader at default parameters (16 x 8-bit counts,
// total 256). Table vectors drive full loads; a scoreboard checks every
// accepted word when the DUT drops in_rdy.
module tb_ans_table_loader;

    localparam int N   = 16;
    localparam int CW  = 8;
    localparam int SW  = 12;
    localparam int TOT = 256;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clear = 1'b0;
    logic [CW-1:0]   in = '0;
    logic            in_vld = 1'b0;
    logic            in_rdy;
    logic [N*CW-1:0] counts;
    logic [N*SW-1:0] cdf;
    logic [3:0]      load_idx;
    logic            tbl_vld;
    logic            err;

    ans_table_loader dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in       (in),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .counts   (counts),
        .cdf      (cdf),
        .load_idx (load_idx),
        .tbl_vld  (tbl_vld),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int cnt;
        int cdfv;
        int nidx;
    } exp_t;

    typedef struct {
        logic [N-1:0][CW-1:0] cnt;
        bit                   vld;
        bit                   er;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[5];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_idx  = 0;
    int   exp_acc  = 0;
    bit   prev_rdy = 1'b0;

    function automatic int get_count(input int i);
        return int'(counts[i*CW +: CW]);
    endfunction

    function automatic int get_cdf(input int i);
        return int'(cdf[i*SW +: SW]);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Scoreboard: an accept shows up as in_rdy falling; the table entry and
    // load_idx must already carry the new word in that cycle.
    always @(negedge clk) begin
        if (prev_rdy && !in_rdy) begin
            if (sb_q.size() == 0) begin
                check("unexpected_accept", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("sb_count[%0d]", e.idx), get_count(e.idx), e.cnt);
                check($sformatf("sb_cdf[%0d]", e.idx), get_cdf(e.idx), e.cdfv);
                check("sb_load_idx", int'(load_idx), e.nidx);
                $display("accept idx=%0d count=%0d cdf=%0d", e.idx, e.cnt, e.cdfv);
            end
        end
        prev_rdy = in_rdy;
    end

    task automatic push_expected(input int v);
        exp_t e;
        e.idx  = exp_idx;
        e.cnt  = v;
        e.cdfv = exp_acc;
        e.nidx = (exp_idx + 1) % N;
        sb_q.push_back(e);
        exp_acc += v;
        exp_idx  = e.nidx;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!in_rdy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_rdy) check("rdy_timeout", 0, 1);
    endtask

    task automatic send_word(input int v);
        int n = 0;
        wait_rdy();
        in     = CW'(v);
        in_vld = 1'b1;
        push_expected(v);
        do begin
            @(posedge clk); #1;
            n++;
        end while (in_rdy && n < 50);
        if (in_rdy) check("ack_timeout", 0, 1);
        in_vld = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear   = 1'b0;
        exp_idx = 0;
        exp_acc = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_rdy"}, int'(in_rdy), 1);
        check({tag, "_load_idx"}, int'(load_idx), 0);
        check({tag, "_tbl_vld"}, int'(tbl_vld), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_counts_zero"}, int'(counts == '0), 1);
        check({tag, "_cdf_zero"}, int'(cdf == '0), 1);
    endtask

    initial begin
        // Vector table: full 16-symbol loads and their verdicts.
        for (int i = 0; i < N; i++) begin
            vecs[0].cnt[i] = 8'd16;
            vecs[1].cnt[i] = 8'd15;
            vecs[2].cnt[i] = 8'd0;
            vecs[3].cnt[i] = (i < 8) ? 8'd32 : 8'd0;
            vecs[4].cnt[i] = 8'd16;
        end
        vecs[2].cnt[0] = 8'd255;
        vecs[2].cnt[1] = 8'd1;
        vecs[4].cnt[0] = 8'd17;
        vecs[0].vld = 1; vecs[0].er = 0;   // uniform, 256
        vecs[1].vld = 0; vecs[1].er = 1;   // 240
        vecs[2].vld = 1; vecs[2].er = 0;   // skewed, 256
        vecs[3].vld = 1; vecs[3].er = 0;   // 8 x 32, 256
        vecs[4].vld = 0; vecs[4].er = 1;   // 257

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        for (int v = 0; v < 5; v++) begin
            int run;
            do_clear();
            check_reset_outputs($sformatf("clear%0d", v));
            for (int i = 0; i < N; i++) send_word(int'(vecs[v].cnt[i]));
            $display("vector %0d loaded: tbl_vld=%0d err=%0d", v, tbl_vld, err);
            check($sformatf("v%0d_tbl_vld", v), int'(tbl_vld), int'(vecs[v].vld));
            check($sformatf("v%0d_err", v), int'(err), int'(vecs[v].er));
            check($sformatf("v%0d_in_rdy", v), int'(in_rdy), 0);
            check($sformatf("v%0d_load_idx", v), int'(load_idx), 0);
            run = 0;
            for (int i = 0; i < N; i++) begin
                check($sformatf("v%0d_cdf[%0d]", v, i), get_cdf(i), run);
                run += int'(vecs[v].cnt[i]);
            end
            // Requests after completion are ignored.
            in = 8'd99; in_vld = 1'b1;
            repeat (3) @(posedge clk);
            #1 in_vld = 1'b0;
            check($sformatf("v%0d_ignore_idx", v), int'(load_idx), 0);
            check($sformatf("v%0d_ignore_cnt0", v), get_count(0), int'(vecs[v].cnt[0]));
            check($sformatf("v%0d_ignore_rdy", v), int'(in_rdy), 0);
            check($sformatf("v%0d_hold_vld", v), int'(tbl_vld), int'(vecs[v].vld));
        end

        // Held request: one accept only.
        do_clear();
        wait_rdy();
        in = 8'd7; in_vld = 1'b1;
        push_expected(7);
        repeat (10) @(posedge clk);
        #1;
        check("held_count0", get_count(0), 7);
        check("held_load_idx", int'(load_idx), 1);
        check("held_in_rdy_low", int'(in_rdy), 0);
        in_vld = 1'b0;
        @(posedge clk); #1;
        check("held_rearm", int'(in_rdy), 1);
        $display("held request: load_idx=%0d", load_idx);

        // Mid-load clear coinciding with the 6th accept.
        do_clear();
        for (int i = 0; i < 5; i++) send_word(16);
        wait_rdy();
        in = 8'd16; in_vld = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_vld = 1'b0;
        exp_idx = 0; exp_acc = 0;
        check("midclr_counts_zero", int'(counts == '0), 1);
        check("midclr_load_idx", int'(load_idx), 0);
        check("midclr_in_rdy", int'(in_rdy), 1);
        for (int i = 0; i < N; i++) send_word(16);
        check("reload_tbl_vld", int'(tbl_vld), 1);
        check("reload_err", int'(err), 0);
        check("reload_cdf15", get_cdf(15), 240);
        $display("mid-load clear then reload: tbl_vld=%0d", tbl_vld);

        // Reset from DONE.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("rst_done");

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ans_table_loader.md
# ans_table_loader

Parametrised successor to the ANS count loader. Receives one symbol count per 4-phase handshake from the pin-level input bus and stores the complete frequency table. While loading, it builds the cumulative-frequency (CDF) table on the fly. After the last symbol it checks that the counts sum to 2^PROB_BITS and reports either a valid table or an error. It sits between the chip input pins and the ANS encoder/decoder core, which read `counts` and `cdf` only while `tbl_vld` is high.

## Interface

Parameters:
- `SYM_COUNT`, default 16: number of symbols; must be ≥2. `SYM_W = $clog2(SYM_COUNT)`.
- `CNT_WIDTH`, default 8: width of one count word.
- `PROB_BITS`, default 8: required table total is `TOTAL = 2^PROB_BITS`.
- Derived: `SUM_W = CNT_WIDTH + SYM_W`, the accumulator and CDF entry width. The sum cannot overflow at this width.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous active-high reset.
- `clear` input 1: synchronous reload request; same effect as `rst`.
- `in` input CNT_WIDTH: count for the next symbol.
- `in_vld` input 1: 4-phase request from the sender.
- `in_rdy` output 1: 4-phase acknowledge; high means ready for a word.
- `counts` output SYM_COUNT*CNT_WIDTH: flattened count table; symbol i occupies `[i*CNT_WIDTH +: CNT_WIDTH]`.
- `cdf` output SYM_COUNT*SUM_W: flattened CDF; `cdf[i] = sum of counts[0..i-1]`, and `cdf[0] = 0`.
- `load_idx` output SYM_W: index of the next symbol to be written.
- `tbl_vld` output 1: table complete and total equals TOTAL.
- `err` output 1: table complete and total differs from TOTAL.

## Operation

States:
- LOAD: accepting words.
- DONE: `tbl_vld` = 1.
- ERR: `err` = 1.

Reset, applied by `rst` or `clear`:
- state = LOAD, `in_rdy` = 1.
- All `counts` and `cdf` entries = 0.
- `load_idx` = 0, accumulator = 0.
- `tbl_vld` = 0, `err` = 0.

Accept (state LOAD, `in_rdy` && `in_vld`):
- `counts[load_idx] <= in`.
- `cdf[load_idx] <= acc`.
- `acc <= acc + in`, with `in` zero-extended to SUM_W.
- `load_idx <= load_idx + 1`.
- `in_rdy <= 0`.

Re-arm: in LOAD with `in_rdy` = 0 and `in_vld` = 0, set `in_rdy <= 1`. A word held with `in_vld` high is therefore accepted exactly once.

Last word (`load_idx` = SYM_COUNT-1, accepted):
- Compare `acc + in` against TOTAL.
- Equal: next state DONE. Unequal: next state ERR.
- `load_idx` wraps to 0.

In DONE and ERR:
- `in_rdy` stays 0 and `in_vld` is ignored.
- Tables hold until `rst` or `clear`.

Boundary rules:
- Zero counts are legal.
- A count equal to TOTAL is representable only if CNT_WIDTH > PROB_BITS.
- Priority: `rst` > `clear` > accept > re-arm.
- `clear` asserted in the same cycle as an accept discards that word.
- `clear` or `rst` mid-load restarts the load at symbol 0.

## Timing

- Accept to table update: the `counts`/`cdf` entry and `load_idx` are visible in the cycle after the accept edge.
- `in_rdy` falls in the cycle after the accept.
- `in_rdy` rises in the cycle after `in_vld` is first seen low, so the minimum handshake period is 2 cycles.
- `tbl_vld` or `err` rises in the cycle after the last accept; there is no extra check cycle.
- `clear` or `rst` takes effect at the next edge; `in_rdy` = 1 in the following cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure

Shared package `ans_pkg` holds:
- Default `SYM_COUNT`, `CNT_WIDTH`, `PROB_BITS`.
- The `SUM_W` derivation.
- The loader state enum (LOAD, DONE, ERR).

Natural sub-module: `ans_hs_rx`, the 4-phase receiver.
- Inputs: `in_vld`, an `enable`, `clear`.
- Outputs: `in_rdy` and a one-cycle `accept` strobe.
- It is reused by later pin-level input blocks.

The table registers, accumulator and state machine stay in `ans_table_loader`.

## Test plan

All scenarios use the defaults SYM_COUNT=16, CNT_WIDTH=8, PROB_BITS=8.

- Valid uniform table: 16 handshakes of 16 each → `tbl_vld` = 1 one cycle after the 16th accept; `cdf[i]` = 16·i; `err` = 0; `in_rdy` stays 0.
- Wrong total: 16 handshakes of 15 each (sum 240) → `err` = 1, `tbl_vld` = 0. Then `clear` → all tables 0, `in_rdy` = 1, `load_idx` = 0.
- Held request: `in_vld` held high for 10 cycles with `in` = 7 → exactly one accept: `counts[0]` = 7, `load_idx` = 1. `in_rdy` returns to 1 one cycle after `in_vld` drops.
- Skewed table: counts 255, 1, then 14 zeros → `tbl_vld` = 1; `cdf[1]` = 255; `cdf[2..15]` = 256.
- Mid-load clear: accept 5 words, then `clear` asserted in the same cycle as the 6th accept → that word is discarded; `counts` all 0; `load_idx` = 0; a full valid reload afterwards succeeds.
- Reset in DONE: from a valid table assert `rst` for one cycle → every output returns to its reset value on the next cycle.
